// File: rtl/poly_sub_decode.sv
// Decapsulation message recovery: msg_i = Compress_q(v_i - w_i mod q, 1), LANES coefficients per cycle.
// Optional range check on v/w coefficients is enabled by defining KYBER_DEC_RANGE_CHK_EN.
module poly_sub_decode #(
  parameter int LANES = 32,
  localparam int KYBER_N = 256,
  localparam int KYBER_Q = 3329,
  localparam int KYBER_R_WIDTH = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [KYBER_N*KYBER_R_WIDTH-1:0]   v,
  input  logic [KYBER_N*KYBER_R_WIDTH-1:0]   w,
  output logic [KYBER_N-1:0]                 msg,
  output logic                               busy,
  output logic                               valid,
  output logic                               err
);

  localparam int GROUPS = KYBER_N / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int BUF_W  = KYBER_N * KYBER_R_WIDTH;
  localparam int GRP_W  = LANES * KYBER_R_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt;
  logic [CW-1:0]       cnt_r;
  logic [BUF_W-1:0]    v_buf_r;
  logic [BUF_W-1:0]    w_buf_r;
  logic [KYBER_N-1:0]  msg_r;
  logic                busy_r;
  logic                valid_r;
  logic                accept_s;
  logic                last_s;
  logic [LANES-1:0]    lane_bits_s;

  // Signed 13-bit difference, single conditional +q, then 1-bit compression window.
  function automatic logic sub_compress(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[12]) begin
      d = d + 13'(KYBER_Q);
    end else begin
      d = d;
    end
    return (d >= 13'd833) && (d <= 13'd2496);
  endfunction

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (cnt_r == CW'(GROUPS - 1));

`ifdef KYBER_DEC_RANGE_CHK_EN
  logic [LANES-1:0] lane_bad_s;
  logic             err_r;

  function automatic logic out_of_range(input logic [11:0] c);
    return c >= 12'(KYBER_Q);
  endfunction
`endif

  // Per-lane arithmetic on the low group of the shifting buffers.
  always_comb begin
    lane_bits_s = '0;
`ifdef KYBER_DEC_RANGE_CHK_EN
    lane_bad_s  = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      lane_bits_s[l] = sub_compress(v_buf_r[l*KYBER_R_WIDTH +: KYBER_R_WIDTH],
                                    w_buf_r[l*KYBER_R_WIDTH +: KYBER_R_WIDTH]);
`ifdef KYBER_DEC_RANGE_CHK_EN
      lane_bad_s[l]  = out_of_range(v_buf_r[l*KYBER_R_WIDTH +: KYBER_R_WIDTH]) ||
                       out_of_range(w_buf_r[l*KYBER_R_WIDTH +: KYBER_R_WIDTH]);
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt = DONE;
        else        state_nxt = RUN;
      end
      DONE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, buffers, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      v_buf_r <= '0;
      w_buf_r <= '0;
      msg_r   <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt == RUN);
      if (accept_s) begin
        v_buf_r <= v;
        w_buf_r <= w;
        msg_r   <= '0;
        valid_r <= 1'b0;
        cnt_r   <= '0;
      end else if (state_r == RUN) begin
        // Buffers shift down so the active group always sits in the low lanes.
        v_buf_r <= v_buf_r >> GRP_W;
        w_buf_r <= w_buf_r >> GRP_W;
        msg_r[cnt_r*LANES +: LANES] <= lane_bits_s;
        if (last_s) begin
          cnt_r   <= '0;
          valid_r <= 1'b1;
        end else begin
          cnt_r   <= cnt_r + CW'(1);
        end
      end
    end
  end

`ifdef KYBER_DEC_RANGE_CHK_EN
  // Sticky range-error flag, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if ((state_r == RUN) && (|lane_bad_s)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign msg   = msg_r;
  assign busy  = busy_r;
  assign valid = valid_r;

endmodule

// File: tb/tb_poly_sub_decode.sv
// Scoreboard bench for poly_sub_decode: expectations are pushed at start and
// compared (msg, err, completion cycle) when valid rises.
module tb_poly_sub_decode;

  localparam int N     = 256;
  localparam int RW    = 12;
  localparam int Q     = 3329;
  localparam int LANES = 32;
  localparam int LAT   = N / LANES;

`ifdef KYBER_DEC_RANGE_CHK_EN
  localparam logic RANGE_ERR_EXP = 1'b1;
`else
  localparam logic RANGE_ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] msg;
    logic         err;
    int           cyc;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N*RW-1:0] v;
  logic [N*RW-1:0] w;
  logic [N-1:0]    msg;
  logic            busy;
  logic            valid;
  logic            err;

  exp_t            sb_q[$];
  int              cyc;
  int              n_checks;
  int              n_fail;
  logic            valid_prev;

  poly_sub_decode #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .v     (v),
    .w     (w),
    .msg   (msg),
    .busy  (busy),
    .valid (valid),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_value(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: round(2d/q) mod 2 with d = (v - w) mod q.
  function automatic logic [N-1:0] model_msg(input logic [N*RW-1:0] vv, input logic [N*RW-1:0] ww);
    logic [N-1:0] m;
    int d;
    for (int i = 0; i < N; i++) begin
      d = int'(vv[i*RW +: RW]) - int'(ww[i*RW +: RW]);
      if (d < 0) d = d + Q;
      m[i] = (((4 * d + Q) / (2 * Q)) % 2) == 1;
    end
    return m;
  endfunction

  function automatic logic [N*RW-1:0] fill(input int c);
    logic [N*RW-1:0] p;
    for (int i = 0; i < N; i++) p[i*RW +: RW] = RW'(c);
    return p;
  endfunction

  // Monitor: each rising valid retires one scoreboard entry.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        chk_value("unexpected_valid", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk_value("msg", msg, e.msg);
        chk_value("err", 256'(err), 256'(e.err));
        chk_value("latency", 256'(cyc), 256'(e.cyc));
        chk_value("busy_at_valid", 256'(busy), 256'(0));
      end
    end
    valid_prev <= valid;
  end

  task automatic pulse_start(input logic [N*RW-1:0] vv, input logic [N*RW-1:0] ww,
                             input bit push, input logic exp_err);
    exp_t e;
    @(negedge clk);
    v = vv;
    w = ww;
    start = 1'b1;
    if (push) begin
      e.msg = model_msg(vv, ww);
      e.err = exp_err;
      e.cyc = cyc + 1 + LAT;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    chk_value("done_timeout", 256'(sb_q.size()), 256'(0));
  endtask

  logic [N*RW-1:0] vt;
  logic [N*RW-1:0] wt;

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; valid_prev = 1'b0;
    rst = 1'b1; start = 1'b0; v = '0; w = '0;
    repeat (3) @(negedge clk);
    chk_value("rst_msg", msg, '0);
    chk_value("rst_valid", 256'(valid), 256'(0));
    chk_value("rst_busy", 256'(busy), 256'(0));
    chk_value("rst_err", 256'(err), 256'(0));
    rst = 1'b0;

    // Nominal ones, with busy checked right after the start edge.
    pulse_start(fill(1665), fill(0), 1'b1, 1'b0);
    chk_value("busy_run", 256'(busy), 256'(1));
    chk_value("valid_run", 256'(valid), 256'(0));
    wait_done();
    chk_value("ones_msg", msg, {N{1'b1}});

    pulse_start(fill(0), fill(0), 1'b1, 1'b0);
    wait_done();

    // Threshold and wrap-around pattern across all groups.
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0:       begin vt[i*RW +: RW] = 12'd0;    wt[i*RW +: RW] = 12'd2496; end
        1:       begin vt[i*RW +: RW] = 12'd0;    wt[i*RW +: RW] = 12'd2497; end
        2:       begin vt[i*RW +: RW] = 12'd2496; wt[i*RW +: RW] = 12'd0;    end
        default: begin vt[i*RW +: RW] = 12'd2497; wt[i*RW +: RW] = 12'd0;    end
      endcase
    end
    pulse_start(vt, wt, 1'b1, 1'b0);
    wait_done();
    chk_value("thresh_msg", msg, {64{4'b0101}});

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        vt[i*RW +: RW] = RW'($urandom_range(0, Q - 1));
        wt[i*RW +: RW] = RW'($urandom_range(0, Q - 1));
      end
      pulse_start(vt, wt, 1'b1, 1'b0);
      wait_done();
    end

    // Inputs change after start: result must reflect latched values.
    pulse_start(fill(1665), fill(0), 1'b1, 1'b0);
    v = fill(0);
    w = fill(1000);
    wait_done();

    // Start during RUN is ignored; completion cycle unchanged.
    pulse_start(fill(1665), fill(0), 1'b1, 1'b0);
    @(negedge clk);
    pulse_start(fill(0), fill(0), 1'b0, 1'b0);
    wait_done();

    // Restart from DONE: valid drops on the start edge.
    pulse_start(fill(0), fill(0), 1'b1, 1'b0);
    chk_value("restart_valid_drop", 256'(valid), 256'(0));
    chk_value("restart_busy", 256'(busy), 256'(1));
    wait_done();

    // Reset mid-run.
    pulse_start(fill(1665), fill(0), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    sb_q.delete();
    chk_value("midrst_msg", msg, '0);
    chk_value("midrst_valid", 256'(valid), 256'(0));
    chk_value("midrst_busy", 256'(busy), 256'(0));
    rst = 1'b0;
    start = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk_value("midrst_idle_valid", 256'(valid), 256'(0));
    pulse_start(fill(1665), fill(0), 1'b1, 1'b0);
    wait_done();

    // Range check: one out-of-range coefficient, then clean data.
    vt = fill(0);
    vt[100*RW +: RW] = 12'd3329;
    pulse_start(vt, fill(0), 1'b1, RANGE_ERR_EXP);
    wait_done();
    pulse_start(fill(1665), fill(0), 1'b1, 1'b0);
    chk_value("err_cleared_on_start", 256'(err), 256'(0));
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
